// File: rtl/service_display_arbiter.sv
// Grants one of four services the shared 4-digit display and push buttons, then hands the display back to the clock.
// Optional idle-timeout revocation is enabled by defining SVC_ARB_TIMEOUT_EN.
module service_display_arbiter #(
  parameter int HOLD_CYC    = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  svc_req,
  input  logic [3:0]  svc_finish,
  input  logic [63:0] svc_num,
  input  logic [15:0] svc_an,
  input  logic [15:0] time_num,
  input  logic [4:0]  push_in,
  output logic [19:0] push_out,
  output logic [3:0]  grant,
  output logic [3:0]  svc_led,
  output logic [15:0] num,
  output logic [3:0]  an,
  output logic        busy,
  output logic        conflict
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_ACTIVE, S_DONE, S_RELEASE} state_t;

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  // Reject nonsensical configurations at elaboration.
  if (HOLD_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("service_display_arbiter: HOLD_CYC and TIMEOUT_CYC must be >= 1");
  end

  state_t          state;
  logic [1:0]      owner;
  logic [15:0]     held_word;
  logic [HW-1:0]   hold_cnt;

`ifdef SVC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0]   idle_cnt;
`endif

  logic [1:0]  req_idx;
  logic        req_multi;
  logic        own_req;
  logic        own_fin;
  logic [15:0] own_num;
  logic [3:0]  own_an;

  always_comb begin
    if (svc_req[0])      req_idx = 2'd0;
    else if (svc_req[1]) req_idx = 2'd1;
    else if (svc_req[2]) req_idx = 2'd2;
    else                 req_idx = 2'd3;
    req_multi = (svc_req & (svc_req - 4'd1)) != 4'd0;
    own_req   = svc_req[owner];
    own_fin   = svc_finish[owner];
    own_num   = svc_num[int'(owner) * 16 +: 16];
    own_an    = svc_an[int'(owner) * 4 +: 4];
  end

  // Buttons reach only the owner, and only once it is fully active.
  always_comb begin
    push_out = '0;
    if (state == S_ACTIVE) push_out[int'(owner) * 5 +: 5] = push_in;
  end

  // NOTE: every register here uses non-blocking assignment so all outputs update from the same pre-edge state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      owner     <= 2'd0;
      held_word <= 16'h0000;
      hold_cnt  <= '0;
      grant     <= 4'b0000;
      svc_led   <= 4'b0000;
      busy      <= 1'b0;
      conflict  <= 1'b0;
      num       <= 16'h0000;
      an        <= 4'b0000;
`ifdef SVC_ARB_TIMEOUT_EN
      idle_cnt  <= '0;
`endif
    end else begin
      conflict <= 1'b0;

      case (state)
        S_ACTIVE: begin num <= own_num;   an <= own_an;  end
        S_DONE:   begin num <= held_word; an <= 4'b1111; end
        default:  begin num <= time_num;  an <= 4'b1111; end
      endcase

      case (state)
        S_IDLE: if (svc_req != 4'b0000) begin
          owner    <= req_idx;
          grant    <= 4'b0001 << req_idx;
          svc_led  <= 4'b0001 << req_idx;
          busy     <= 1'b1;
          conflict <= req_multi;
          state    <= S_ARM;
        end
        S_ARM: begin
          if (!own_req) begin
            grant   <= 4'b0000;
            svc_led <= 4'b0000;
            state   <= S_RELEASE;
          end else if (push_in == 5'b00000) begin
            state   <= S_ACTIVE;
`ifdef SVC_ARB_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        S_ACTIVE: begin
          // Finish takes priority over a simultaneous request drop.
          if (own_fin) begin
            held_word <= own_num;
            hold_cnt  <= '0;
            grant     <= 4'b0000;
            svc_led   <= 4'b0000;
            state     <= S_DONE;
          end else if (!own_req) begin
            grant     <= 4'b0000;
            svc_led   <= 4'b0000;
            state     <= S_RELEASE;
          end
`ifdef SVC_ARB_TIMEOUT_EN
          else if (push_in != 5'b00000) begin
            idle_cnt  <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            grant     <= 4'b0000;
            svc_led   <= 4'b0000;
            state     <= S_RELEASE;
          end else begin
            idle_cnt  <= idle_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          if (hold_cnt == HOLD_LAST) state <= S_RELEASE;
          else                       hold_cnt <= hold_cnt + 1'b1;
        end
        S_RELEASE: if (!own_req) begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
